// File: rtl/usb_interface_axi_slave_mem.sv
`default_nettype none
// ============================================================================
// Module  : usb_interface_axi_slave_mem
// Brief   : AXI4 INCR/FIXED burst slave over a word-addressed byte-strobed RAM.
// Revision: 1.0 - initial release
// ============================================================================
module usb_interface_axi_slave_mem #(
  parameter int C_S_AXI_DATA_WIDTH    = 32,
  parameter int C_S_AXI_ADDR_WIDTH    = 10,
  parameter int C_S_AXI_BURST_LEN_MAX = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam int NBYTE = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  wstate_t    wstate_q, wstate_d;
  logic       awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [7:0] wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic       wfixed_q, wfixed_d, werr_q, werr_d;
  logic       mem_we, w_last_beat, w_beat_err;

  rstate_t    rstate_q, rstate_d;
  logic       arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0] rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0] ridx_q, ridx_d, r_next_idx, ar_idx;
  logic [7:0] rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic       rfixed_q, rfixed_d, rerr_q, rerr_d, ar_err;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Beat count follows AWLEN; a WLAST disagreeing with it poisons the burst.
  assign w_last_beat = (wbeat_q == wlen_q);
  assign w_beat_err  = (S_AXI_WLAST != w_last_beat);

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    wfixed_d  = wfixed_q;
    werr_d    = werr_q;
    mem_we    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awready_q && S_AXI_AWVALID) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          widx_d    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          wlen_d    = S_AXI_AWLEN;
          wbeat_d   = 8'd0;
          wfixed_d  = (S_AXI_AWBURST == 2'b00);
          werr_d    = S_AXI_AWBURST[1] ||
                      ((int'(S_AXI_AWLEN) + 1) > C_S_AXI_BURST_LEN_MAX);
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          mem_we  = !(werr_q || w_beat_err);
          widx_d  = wfixed_q ? widx_q : widx_q + 1'b1;
          wbeat_d = wbeat_q + 8'd1;
          werr_d  = werr_q || w_beat_err;
          if (w_last_beat) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (werr_q || w_beat_err) ? C_RESP_SLVERR : C_RESP_OKAY;
            wstate_d = W_RESP;
          end
        end
      end
      default: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
    endcase
  end

  assign ar_idx     = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_err     = S_AXI_ARBURST[1] || ((int'(S_AXI_ARLEN) + 1) > C_S_AXI_BURST_LEN_MAX);
  assign r_next_idx = rfixed_q ? ridx_q : ridx_q + 1'b1;

  // Read data is registered at the handshake edge so a same-cycle write is not seen.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rfixed_d  = rfixed_q;
    rerr_d    = rerr_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arready_q && S_AXI_ARVALID) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          ridx_d    = ar_idx;
          rlen_d    = S_AXI_ARLEN;
          rbeat_d   = 8'd0;
          rfixed_d  = (S_AXI_ARBURST == 2'b00);
          rerr_d    = ar_err;
          rlast_d   = (S_AXI_ARLEN == 8'd0);
          rresp_d   = ar_err ? C_RESP_SLVERR : C_RESP_OKAY;
          rdata_d   = ar_err ? '0 : mem[ar_idx];
          rstate_d  = R_DATA;
        end
      end
      default: begin
        if (S_AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rresp_d   = C_RESP_OKAY;
            rdata_d   = '0;
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
          end else begin
            ridx_d  = r_next_idx;
            rbeat_d = rbeat_q + 8'd1;
            rlast_d = ((rbeat_q + 8'd1) == rlen_q);
            rdata_d = rerr_q ? '0 : mem[r_next_idx];
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      widx_q    <= '0;
      wlen_q    <= 8'd0;
      wbeat_q   <= 8'd0;
      wfixed_q  <= 1'b0;
      werr_q    <= 1'b0;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      ridx_q    <= '0;
      rlen_q    <= 8'd0;
      rbeat_q   <= 8'd0;
      rfixed_q  <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      wfixed_q  <= wfixed_d;
      werr_q    <= werr_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rfixed_q  <= rfixed_d;
      rerr_q    <= rerr_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (S_AXI_WSTRB[b]) mem[widx_q][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_interface_axi_slave_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_usb_interface_axi_slave_mem
// Brief   : Self-checking bench with a word-array memory model and random bursts.
// Revision: 1.0 - initial release
// ============================================================================
module tb_usb_interface_axi_slave_mem;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [9:0]  awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;

  usb_interface_axi_slave_mem dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWBURST(awburst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARBURST(arburst),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [31:0] model [256];
  logic [31:0] wr_data [256];
  logic [3:0]  wr_strb [256];
  logic [31:0] rd_data [$];
  logic [1:0]  rd_resp [$];
  logic        rd_last [$];
  int          stall_changes, bvalid_drops;
  logic [1:0]  last_bresp;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Legal bursts only: beat i lands at start (FIXED) or start+i mod depth (INCR).
  function automatic void model_apply(input logic [9:0] addr, input int len, input logic [1:0] burst);
    for (int i = 0; i <= len; i++) begin
      int idx = (burst == FIXED) ? int'(addr[9:2]) : (int'(addr[9:2]) + i) % 256;
      model[idx] = merge(model[idx], wr_data[i], wr_strb[i]);
    end
  endfunction

  task automatic timeout(input string what);
    checks++; errors++;
    $display("FAIL timeout %s: handshake never happened (required within budget)", what);
  endtask

  task automatic do_write(input logic [9:0] addr, input int len, input logic [1:0] burst,
                          input int bad_beat);
    int t = 0;
    awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1;
    while (!awready && t < 50) begin tick(); t++; end
    if (t >= 50) timeout("aw");
    tick(); awvalid = 0;
    for (int i = 0; i <= len; i++) begin
      wdata = wr_data[i]; wstrb = wr_strb[i];
      wlast = (i == len) ^ (i == bad_beat); wvalid = 1; t = 0;
      while (!wready && t < 50) begin tick(); t++; end
      if (t >= 50) timeout("w");
      tick();
    end
    wvalid = 0; wlast = 0;
  endtask

  task automatic do_bresp(input int hold);
    int t = 0;
    bvalid_drops = 0;
    while (!bvalid && t < 50) begin tick(); t++; end
    if (t >= 50) timeout("b");
    last_bresp = bresp;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!bvalid || bresp !== last_bresp) bvalid_drops++;
    end
    bready = 1; tick(); bready = 0;
  endtask

  // mode 0: RREADY high; 1: pattern 1,0,0 repeating; 2: random.
  task automatic do_read(input logic [9:0] addr, input int len, input logic [1:0] burst,
                         input int mode);
    int t = 0, cyc = 0;
    logic prev_stall = 0;
    logic [31:0] sd; logic [1:0] sr; logic sl;
    rd_data.delete(); rd_resp.delete(); rd_last.delete(); stall_changes = 0;
    araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1;
    while (!arready && t < 50) begin tick(); t++; end
    if (t >= 50) timeout("ar");
    tick(); arvalid = 0;
    while (rd_data.size() < len + 1 && cyc < 2000) begin
      if (prev_stall && (!rvalid || rdata !== sd || rresp !== sr || rlast !== sl))
        stall_changes++;
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      #0;
      if (rvalid && rready) begin
        rd_data.push_back(rdata); rd_resp.push_back(rresp); rd_last.push_back(rlast);
      end
      prev_stall = rvalid && !rready;
      sd = rdata; sr = rresp; sl = rlast;
      tick(); cyc++;
    end
    rready = 0;
    if (cyc >= 2000) timeout("r");
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp, rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    tick(); tick(); rst_n = 1; tick();
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: awready=%b arready=%b required 1 1", awready, arready);
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 16; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
    do_write(10'h000, 15, INCR, -1); model_apply(10'h000, 15, INCR); do_bresp(0);
    checks++;
    if (last_bresp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b required 00", last_bresp); end
    do_read(10'h000, 15, INCR, 0);
    for (int i = 0; i < rd_data.size(); i++) begin
      checks++;
      if (rd_data[i] !== 32'(i + 1) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL incr_beat%0d: got data=%h resp=%b last=%b required %h 00 %b",
                 i, rd_data[i], rd_resp[i], rd_last[i], i + 1, i == 15);
      end
    end
  endtask

  task automatic test_strobe();
    wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'hF;
    do_write(10'h020, 0, INCR, -1); model_apply(10'h020, 0, INCR); do_bresp(0);
    wr_data[0] = 32'h11223344; wr_strb[0] = 4'b0101;
    do_write(10'h020, 0, INCR, -1); model_apply(10'h020, 0, INCR); do_bresp(0);
    do_read(10'h020, 0, INCR, 0);
    checks++;
    if (rd_data.size() != 1 || rd_data[0] !== 32'hAA22CC44 || rd_last[0] !== 1'b1) begin
      errors++; $display("FAIL strobe: got %h required aa22cc44", rd_data.size() ? rd_data[0] : 0);
    end
  endtask

  task automatic test_fixed();
    wr_data[0] = 32'hDEAD0000; wr_data[1] = 32'hDEAD0001; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    do_write(10'h040, 1, INCR, -1); model_apply(10'h040, 1, INCR); do_bresp(0);
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
    do_write(10'h040, 3, FIXED, -1); model_apply(10'h040, 3, FIXED); do_bresp(0);
    do_read(10'h040, 1, INCR, 0);
    checks++;
    if (rd_data.size() != 2 || rd_data[0] !== 32'd4 || rd_data[1] !== 32'hDEAD0001) begin
      errors++; $display("FAIL fixed: got %h %h required 00000004 dead0001",
                         rd_data.size() > 0 ? rd_data[0] : 0, rd_data.size() > 1 ? rd_data[1] : 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
    do_write(10'h080, 7, INCR, -1); model_apply(10'h080, 7, INCR); do_bresp(5);
    checks++;
    if (bvalid_drops != 0 || last_bresp !== 2'b00) begin
      errors++; $display("FAIL bvalid_hold: drops=%0d bresp=%b required 0 00", bvalid_drops, last_bresp);
    end
    do_read(10'h080, 7, INCR, 1);
    checks++;
    if (stall_changes != 0) begin
      errors++; $display("FAIL stall_stable: changes=%0d required 0", stall_changes);
    end
    for (int i = 0; i < rd_data.size(); i++) begin
      checks++;
      if (rd_data[i] !== model[32 + i] || rd_last[i] !== (i == 7)) begin
        errors++; $display("FAIL stall_beat%0d: got %h last=%b required %h %b",
                           i, rd_data[i], rd_last[i], model[32 + i], i == 7);
      end
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h5A5A0000 + 32'(i); wr_strb[i] = 4'hF; end
    do_write(10'h300, 3, INCR, 1); do_bresp(0);
    checks++;
    if (last_bresp !== 2'b10) begin errors++; $display("FAIL early_wlast: got %b required 10", last_bresp); end
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hC0DE0000 + 32'(i);
    do_write(10'h060, 3, INCR, -1); model_apply(10'h060, 3, INCR); do_bresp(0);
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hBAD00000 + 32'(i);
    do_write(10'h060, 3, WRAP, -1); do_bresp(0);
    checks++;
    if (last_bresp !== 2'b10) begin errors++; $display("FAIL wrap_bresp: got %b required 10", last_bresp); end
    do_read(10'h060, 3, INCR, 0);
    for (int i = 0; i < rd_data.size(); i++) begin
      checks++;
      if (rd_data[i] !== model[24 + i]) begin
        errors++; $display("FAIL wrap_mem%0d: got %h required %h", i, rd_data[i], model[24 + i]);
      end
    end
    do_read(10'h060, 3, WRAP, 0);
    for (int i = 0; i < rd_data.size(); i++) begin
      checks++;
      if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 3)) begin
        errors++; $display("FAIL wrap_read%0d: got %h resp=%b last=%b required 0 10 %b",
                           i, rd_data[i], rd_resp[i], rd_last[i], i == 3);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int t = 0;
    araddr = 10'h000; arlen = 8'd15; arburst = INCR; arvalid = 1;
    while (!arready && t < 50) begin tick(); t++; end
    tick(); arvalid = 0; rready = 1;
    repeat (5) tick();
    rst_n = 0; #1;
    checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0) begin
      errors++; $display("FAIL reset_mid_rvalid: got rvalid=%b required 0", rvalid);
    end
    rready = 0; tick(); tick(); rst_n = 1; tick();
    checks++;
    if (arready !== 1'b1 || awready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_ready: arready=%b awready=%b required 1 1", arready, awready);
    end
    do_read(10'h000, 15, INCR, 2);
    for (int i = 0; i < rd_data.size(); i++) begin
      checks++;
      if (rd_data[i] !== model[i] || rd_last[i] !== (i == 15)) begin
        errors++; $display("FAIL reset_mid_beat%0d: got %h required %h", i, rd_data[i], model[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int len = $urandom_range(0, 15);
      int idx = $urandom_range(0, 191 - len);
      logic [1:0] burst = ($urandom_range(0, 2) == 0) ? FIXED : INCR;
      logic [9:0] addr = 10'(idx * 4 + $urandom_range(0, 3));
      for (int i = 0; i <= len; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
      do_write(addr, len, burst, -1); model_apply(addr, len, burst); do_bresp($urandom_range(0, 3));
      checks++;
      if (last_bresp !== 2'b00) begin errors++; $display("FAIL rand%0d_bresp: got %b required 00", n, last_bresp); end
      do_read(addr, len, burst, 2);
      for (int i = 0; i < rd_data.size(); i++) begin
        int e = (burst == FIXED) ? idx : idx + i;
        checks++;
        if (rd_data[i] !== model[e] || rd_last[i] !== (i == len)) begin
          errors++; $display("FAIL rand%0d_beat%0d: got %h last=%b required %h %b",
                             n, i, rd_data[i], rd_last[i], model[e], i == len);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_strobe();
    test_fixed();
    test_back_to_back();
    test_errors();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
